// File: rtl/usart_pkg.sv
// Shared definitions for the usart transmit-side arbiter: FSM encoding,
// idle-counter width and a small counter helper.
package usart_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_t;

    localparam int IDLE_CNT_W = 12;

    // Saturating increment so the idle counter can never wrap back to zero.
    function automatic logic [IDLE_CNT_W-1:0] idle_cnt_inc(input logic [IDLE_CNT_W-1:0] cnt);
        logic [IDLE_CNT_W-1:0] res;
        if (cnt == {IDLE_CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + 12'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority search: the first asserted request at or above ptr,
// wrapping from the top port back to port 0, returned one-hot.
module rr_priority_select #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] pick,
    output logic                 any
);

    logic [PTR_W:0]   sum_s;
    logic [PTR_W-1:0] idx_s;

    // Walk the ports starting at ptr and keep the first requester found.
    always_comb begin
        pick  = '0;
        any   = 1'b0;
        sum_s = '0;
        idx_s = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum_s = {1'b0, ptr} + (PTR_W+1)'(k);
            sum_s = (sum_s >= (PTR_W+1)'(NUM_PORTS)) ? (sum_s - (PTR_W+1)'(NUM_PORTS)) : sum_s;
            idx_s = sum_s[PTR_W-1:0];
            if (!any && req[idx_s]) begin
                pick[idx_s] = 1'b1;
                any         = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/usart_tx_arbiter.sv
// Arbitrates several byte streams onto one shared usart_tx input. A grant is
// held for a whole message (until a last byte) or until the owner stays idle
// for LOCK_TIMEOUT cycles; data and handshakes pass through combinationally.
module usart_tx_arbiter
    import usart_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   in_valid,
    output logic [NUM_PORTS-1:0]   in_ready,
    input  logic [8*NUM_PORTS-1:0] in_data,
    input  logic [NUM_PORTS-1:0]   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic [NUM_PORTS-1:0]   grant,
    output logic                   timeout
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    arb_state_t              state_r, state_nxt_s;
    logic [NUM_PORTS-1:0]    grant_r, grant_nxt_s;
    logic [PTR_W-1:0]        owner_r, owner_nxt_s;
    logic [PTR_W-1:0]        rr_ptr_r, rr_ptr_nxt_s;
    logic [IDLE_CNT_W-1:0]   idle_cnt_r, idle_cnt_nxt_s;
    logic                    timeout_r, timeout_nxt_s;

    logic [NUM_PORTS-1:0]    pick_s;
    logic                    any_s;
    logic [PTR_W-1:0]        pick_idx_s;
    logic [PTR_W-1:0]        owner_succ_s;
    logic                    owner_valid_s;
    logic                    owner_last_s;
    logic                    xfer_s;

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_select (
        .req  (in_valid),
        .ptr  (rr_ptr_r),
        .pick (pick_s),
        .any  (any_s)
    );

    // Convert the one-hot pick into the owner index used for the data mux.
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick_s[i]) begin
                pick_idx_s = PTR_W'(i);
            end else begin
                pick_idx_s = pick_idx_s;
            end
        end
    end

    // Owner-side view: its valid/last, the handshake and the next rr pointer.
    always_comb begin
        owner_valid_s = in_valid[owner_r];
        owner_last_s  = in_last[owner_r];
        xfer_s        = (state_r == ARB_GRANTED) && owner_valid_s && out_ready;
        owner_succ_s  = (owner_r == PTR_W'(NUM_PORTS - 1)) ? {PTR_W{1'b0}} : (owner_r + PTR_W'(1));
    end

    // Next-state logic: arbitration in IDLE, hold/release decisions in GRANTED.
    always_comb begin
        state_nxt_s    = state_r;
        grant_nxt_s    = grant_r;
        owner_nxt_s    = owner_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        idle_cnt_nxt_s = idle_cnt_r;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (any_s) begin
                    state_nxt_s    = ARB_GRANTED;
                    grant_nxt_s    = pick_s;
                    owner_nxt_s    = pick_idx_s;
                    idle_cnt_nxt_s = '0;
                end else begin
                    grant_nxt_s    = '0;
                end
            end
            ARB_GRANTED: begin
                if (xfer_s && owner_last_s) begin
                    state_nxt_s    = ARB_IDLE;
                    grant_nxt_s    = '0;
                    rr_ptr_nxt_s   = owner_succ_s;
                    idle_cnt_nxt_s = '0;
                end else if (xfer_s) begin
                    idle_cnt_nxt_s = '0;
                end else if (!owner_valid_s) begin
                    // Owner idle: this cycle is the LOCK_TIMEOUT-th consecutive one.
                    if (idle_cnt_r == IDLE_CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_nxt_s    = ARB_IDLE;
                        grant_nxt_s    = '0;
                        rr_ptr_nxt_s   = owner_succ_s;
                        idle_cnt_nxt_s = '0;
                        timeout_nxt_s  = 1'b1;
                    end else begin
                        idle_cnt_nxt_s = idle_cnt_inc(idle_cnt_r);
                    end
                end else begin
                    // Byte presented but usart_tx is stalling: not idle time.
                    idle_cnt_nxt_s = idle_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = ARB_IDLE;
                grant_nxt_s    = '0;
                idle_cnt_nxt_s = '0;
            end
        endcase
    end

    // State register block with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ARB_IDLE;
            grant_r    <= '0;
            owner_r    <= '0;
            rr_ptr_r   <= '0;
            idle_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            grant_r    <= grant_nxt_s;
            owner_r    <= owner_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            idle_cnt_r <= idle_cnt_nxt_s;
            timeout_r  <= timeout_nxt_s;
        end
    end

    // Combinational passthrough between the owner and usart_tx.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        in_ready  = '0;
        if (state_r == ARB_GRANTED) begin
            out_valid = owner_valid_s;
            out_data  = in_data[{owner_r, 3'b000} +: 8];
            in_ready  = out_ready ? grant_r : '0;
        end else begin
            out_valid = 1'b0;
            out_data  = 8'h00;
            in_ready  = '0;
        end
    end

    assign grant   = grant_r;
    assign timeout = timeout_r;

endmodule

// File: doc/usart_tx_arbiter.md
USART_TX_ARBITER -- requirements
Module: usart_tx_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of requester ports (2..8).
REQ-002 Parameter LOCK_TIMEOUT, default 255, idle cycles before a held grant is forcibly released (1..4095).
REQ-003 clock  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  NUM_PORTS  per-port byte valid.
REQ-006 in_ready  output  NUM_PORTS  per-port byte accepted.
REQ-007 in_data  input  8*NUM_PORTS  per-port byte; port i occupies bits [8i+7:8i].
REQ-008 in_last  input  NUM_PORTS  per-port end-of-message marker, qualified by in_valid.
REQ-009 out_valid  output  1  byte valid towards the shared usart_tx.
REQ-010 out_ready  input  1  usart_tx ready.
REQ-011 out_data  output  8  byte towards usart_tx.
REQ-012 grant  output  NUM_PORTS  one-hot current owner, zero when idle.
REQ-013 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-014 States: IDLE, GRANTED; no other state is reachable.
REQ-015 IDLE: grant=0, out_valid=0, in_ready=0.
REQ-016 IDLE with any in_valid high: next edge enters GRANTED, owner = first asserted port searching upward from rr_ptr, wrapping NUM_PORTS-1 -> 0.
REQ-017 Arbitration latency is exactly one cycle from in_valid to grant.
REQ-018 GRANTED: out_valid = in_valid[owner], out_data = in_data[owner], in_ready[owner] = out_ready; all other in_ready bits 0 (combinational passthrough).
REQ-019 Transfer = out_valid & out_ready; a transfer with in_last[owner]=1 returns to IDLE next edge.
REQ-020 Grant is held across bytes until a last transfer or timeout; other ports' in_valid has no effect while GRANTED.
REQ-021 On leaving GRANTED (last or timeout) rr_ptr <= owner+1 modulo NUM_PORTS.
REQ-022 Idle counter (12 bits) clears on entering GRANTED and on every transfer; increments each GRANTED cycle with in_valid[owner]=0.
REQ-023 Counter reaching LOCK_TIMEOUT: next edge returns to IDLE and pulses timeout for one cycle; no byte is lost.
REQ-024 in_valid[owner] high while out_ready low does not advance the counter (backpressure is not idle).
REQ-025 Single requester only: re-granted to the same port after one IDLE cycle.
REQ-026 Requesters shall hold in_data/in_last stable while in_valid high and not accepted; arbiter does not register data.

Reset
REQ-027 reset high: state=IDLE, rr_ptr=0, counter=0, grant=0, timeout=0, out_valid=0, in_ready=0, immediately and asynchronously.
REQ-028 Reset mid-message abandons the grant; no partial transfer completes after reset deasserts; first post-reset grant uses rr_ptr=0.

Structure
REQ-029 State encoding and counter width constant live in shared package usart_pkg.
REQ-030 Round-robin priority search is one sub-module, rr_priority_select (request vector, pointer -> one-hot pick, any).
REQ-031 Single flat register block; no async FIFOs or clock crossings inside; intended to sit on the tx_bit_clock domain ahead of usart_tx.

Verification
REQ-032 Ports 0 and 2 valid together after reset -> grant=0001 next cycle; after port 0 sends 0x41,0x42(last) -> IDLE one cycle, then grant=0100.
REQ-033 All four ports continuously valid, each message one byte with last=1 -> grants rotate 0001,0010,0100,1000,0001.
REQ-034 Port 1 granted, sends 0x10 without last, then drops valid; LOCK_TIMEOUT=8 -> timeout pulse exactly 8 idle cycles later, grant=0, rr_ptr=2.
REQ-035 Port 3 granted, in_valid high, out_ready low 300 cycles -> no timeout, out_data stable, transfer on first out_ready high.
REQ-036 reset asserted while port 0 mid-message (byte 0x55 presented, out_ready low) -> grant, out_valid, in_ready go 0 without a clock edge; 0x55 never transferred.
REQ-037 Only port 2 valid, back-to-back last bytes 0xA0,0xA1 -> each granted to port 2 with one IDLE cycle between.
